// File: rtl/ram_pkg.sv
// Shared types and defaults for the clearable RAM.
//   state_t : clear-engine FSM states
//   src_t   : which register currently drives data_out
package ram_pkg;

   localparam int unsigned DEF_DATA_W      = 8;
   localparam int unsigned DEF_ADDR_W      = 8;
   localparam int unsigned DEF_DEPTH       = 256;
   localparam bit          DEF_WRITE_FIRST = 1'b1;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_ARR  = 2'd1,
      SRC_BYP  = 2'd2
   } src_t;

endpackage

// File: rtl/ram_array.sv
// Storage only: one synchronous write port, one synchronous read port, no reset.
//   we/waddr/wdata : write port
//   re/raddr       : read port, rdata updates only on a read and otherwise holds
module ram_array #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Read returns the pre-write contents when both ports hit one address.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata      <= mem[raddr];
   end

endmodule

// File: rtl/ram_clr.sv
// Single-port RAM with a hardware zero-fill engine.
//   clk, rst      : clock, asynchronous active-high reset
//   clr           : restart the zero-fill
//   we, re, addr  : access request, data_in is write data
//   data_out      : last read data, held between reads
//   rd_valid, err : one-cycle pulses for an accepted read / a rejected access
//   busy          : clear in progress, accesses rejected
module ram_clr
   import ram_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter bit          WRITE_FIRST = DEF_WRITE_FIRST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              err
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t            state_q, state_d;
   src_t              src_q, src_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] byp_q;
   logic              rd_valid_d, err_d;
   logic              mem_we, mem_re, in_range, acc;
   logic [AW-1:0]     mem_wa;
   logic [DATA_W-1:0] mem_wd, mem_rd;

   assign acc      = we | re;
   assign in_range = ({1'b0, addr} < CNT_W'(DEPTH));

   // Next-state, clear counter, write mux and strobes.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      src_d      = src_q;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_wa     = AW'(addr);
      mem_wd     = data_in;
      rd_valid_d = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         CLEAR: begin
            mem_we = 1'b1;
            mem_wa = AW'(cnt_q);
            mem_wd = '0;
            err_d  = acc;
            if (clr) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(DEPTH - 1)) begin
               cnt_d   = '0;
               state_d = READY;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         READY: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
               err_d   = acc;
            end else if (acc && !in_range) begin
               err_d = 1'b1;
            end else begin
               mem_we = we;
               mem_re = re;
               if (re) begin
                  rd_valid_d = 1'b1;
                  src_d      = (WRITE_FIRST && we) ? SRC_BYP : SRC_ARR;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // State and strobe registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= CLEAR;
         cnt_q    <= '0;
         src_q    <= SRC_ZERO;
         byp_q    <= '0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         src_q    <= src_d;
         rd_valid <= rd_valid_d;
         err      <= err_d;
         busy     <= (state_d == CLEAR);
         if (src_d == SRC_BYP && rd_valid_d) byp_q <= data_in;
      end
   end

   // data_out is a select between held registers; array rdata only moves on accepted reads.
   always_comb begin
      unique case (src_q)
         SRC_ARR: data_out = mem_rd;
         SRC_BYP: data_out = byp_q;
         default: data_out = '0;
      endcase
   end

   ram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_wa),
      .wdata (mem_wd),
      .re    (mem_re),
      .raddr (AW'(addr)),
      .rdata (mem_rd)
   );

endmodule

// File: tb/tb_ram_clr.sv
// Directed bench: default instance, WRITE_FIRST=0 instance, DEPTH=200 instance, shared stimulus.
module tb_ram_clr;

   logic       clk = 1'b0;
   logic       rst, clr, we, re;
   logic [7:0] addr, data_in;

   logic [7:0] dout_a, dout_b, dout_c;
   logic       vld_a, vld_b, vld_c;
   logic       bsy_a, bsy_b, bsy_c;
   logic       err_a, err_b, err_c;

   int n_cmp = 0;
   int n_bad = 0;
   int n, n200;

   always #5 clk = ~clk;

   ram_clr u_dut (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .re(re), .addr(addr), .data_in(data_in),
      .data_out(dout_a), .rd_valid(vld_a), .busy(bsy_a), .err(err_a)
   );

   ram_clr #(.WRITE_FIRST(1'b0)) u_wf0 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .re(re), .addr(addr), .data_in(data_in),
      .data_out(dout_b), .rd_valid(vld_b), .busy(bsy_b), .err(err_b)
   );

   ram_clr #(.DEPTH(200)) u_d200 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .re(re), .addr(addr), .data_in(data_in),
      .data_out(dout_c), .rd_valid(vld_c), .busy(bsy_c), .err(err_c)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count edges until busy of the default instance drops, bounded.
   task automatic wait_clear(output int edges);
      edges = 0;
      while (bsy_a && edges < 1000) begin
         step();
         edges++;
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; addr = '0; data_in = '0;
      #12;
      chk("rst_dout",  32'(dout_a), 32'h0);
      chk("rst_vld",   32'(vld_a),  32'h0);
      chk("rst_err",   32'(err_a),  32'h0);
      chk("rst_busy",  32'(bsy_a),  32'h1);
      step();

      // Release reset; a read in the first clear cycle must be rejected.
      rst = 1'b0; re = 1'b1; addr = 8'h00;
      step(); n = 1; n200 = 0;
      chk("clr_rd_err",   32'(err_c), 32'h1);
      chk("clr_rd_vld",   32'(vld_c), 32'h0);
      chk("clr_rd_err_a", 32'(err_a), 32'h1);
      re = 1'b0;
      while (bsy_a && n < 1000) begin
         step(); n++;
         if (!bsy_c && n200 == 0) n200 = n;
      end
      chk("busy_edges_256", 32'(n),    32'd256);
      chk("busy_edges_200", 32'(n200), 32'd200);

      // Cleared contents at bottom, middle and top; back-to-back reads.
      re = 1'b1; addr = 8'h00; step();
      chk("rd0_dout", 32'(dout_a), 32'h0);
      chk("rd0_vld",  32'(vld_a),  32'h1);
      addr = 8'h80; step();
      chk("rd128_dout", 32'(dout_a), 32'h0);
      addr = 8'hFF; step();
      chk("rd255_dout", 32'(dout_a), 32'h0);
      chk("rd255_vld",  32'(vld_a),  32'h1);
      re = 1'b0; step();
      chk("idle_vld", 32'(vld_a), 32'h0);

      // Write then read.
      we = 1'b1; addr = 8'h10; data_in = 8'hA5; step();
      chk("wr_vld", 32'(vld_a), 32'h0);
      chk("wr_err", 32'(err_a), 32'h0);
      we = 1'b0; re = 1'b1; step();
      chk("rd10_a", 32'(dout_a), 32'hA5);
      chk("rd10_b", 32'(dout_b), 32'hA5);
      chk("rd10_vld", 32'(vld_a), 32'h1);
      re = 1'b0; step();
      chk("rd10_vld_drop", 32'(vld_a),  32'h0);
      chk("rd10_hold",     32'(dout_a), 32'hA5);

      // Read during write.
      we = 1'b1; re = 1'b1; data_in = 8'h3C; step();
      chk("rdw_wf1", 32'(dout_a), 32'h3C);
      chk("rdw_wf0", 32'(dout_b), 32'hA5);
      chk("rdw_vld", 32'(vld_b),  32'h1);
      we = 1'b0; step();
      chk("rdw_after_wf1", 32'(dout_a), 32'h3C);
      chk("rdw_after_wf0", 32'(dout_b), 32'h3C);
      re = 1'b0;

      // Out of range only for DEPTH=200.
      we = 1'b1; addr = 8'hC8; data_in = 8'h77; step();
      chk("oor_wr_err_c", 32'(err_c),  32'h1);
      chk("oor_wr_err_a", 32'(err_a),  32'h0);
      chk("oor_wr_dout",  32'(dout_c), 32'h3C);
      we = 1'b0; re = 1'b1; step();
      chk("oor_rd_err_c", 32'(err_c),  32'h1);
      chk("oor_rd_vld_c", 32'(vld_c),  32'h0);
      chk("oor_rd_dout_c", 32'(dout_c), 32'h3C);
      chk("inr_rd_dout_a", 32'(dout_a), 32'h77);
      re = 1'b0;

      // clr together with a write.
      we = 1'b1; addr = 8'h05; data_in = 8'hFF; step();
      we = 1'b0; re = 1'b1; step();
      chk("rd05_ff", 32'(dout_a), 32'hFF);
      re = 1'b0; clr = 1'b1; we = 1'b1; addr = 8'h06; data_in = 8'h11; step();
      chk("clr_we_err",  32'(err_a), 32'h1);
      chk("clr_we_busy", 32'(bsy_a), 32'h1);
      clr = 1'b0; we = 1'b0;
      wait_clear(n);
      chk("clr_edges", 32'(n), 32'd256);
      re = 1'b1; addr = 8'h05; step();
      chk("clr_rd05", 32'(dout_a), 32'h0);
      addr = 8'h06; step();
      chk("clr_rd06", 32'(dout_a), 32'h0);
      chk("clr_rd06_vld", 32'(vld_a), 32'h1);

      // Reset in the middle of a clear.
      re = 1'b1; addr = 8'h80; step();
      we = 1'b1; re = 1'b0; data_in = 8'h5A; step();
      we = 1'b0; re = 1'b1; step();
      chk("pre_rst_dout", 32'(dout_a), 32'h5A);
      re = 1'b0; clr = 1'b1; step();
      clr = 1'b0;
      for (int i = 0; i < 100; i++) step();
      chk("mid_busy", 32'(bsy_a), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("arst_dout", 32'(dout_a), 32'h0);
      chk("arst_busy", 32'(bsy_a),  32'h1);
      chk("arst_vld",  32'(vld_a),  32'h0);
      chk("arst_err",  32'(err_a),  32'h0);
      step();
      rst = 1'b0;
      wait_clear(n);
      chk("rst_clear_edges", 32'(n), 32'd256);
      re = 1'b1; addr = 8'h80; step();
      chk("rst_rd80", 32'(dout_a), 32'h0);
      re = 1'b0; step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_clr.md
# ram_clr

Parametrised single-port synchronous RAM with a hardware clear engine, the next generation of the CPU's 256×8 data memory. After reset, or on request, it zero-fills every word, one per cycle, and reports busy while doing so. In normal operation it performs one-cycle-latency reads with a valid strobe, a configurable read-during-write policy, and error flagging for out-of-range or blocked accesses. It sits between the CPU datapath/control unit and storage, and is a drop-in for the existing memory when `DATA_W=8`, `ADDR_W=8` and `DEPTH=256`.

## Interface
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 8: address width in bits.
- `DEPTH`, 256: number of words; must satisfy 2 ≤ `DEPTH` ≤ 2^`ADDR_W`.
- `WRITE_FIRST`, 1: read-during-write policy. 1 returns the new data; 0 returns the old data.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous request to restart the zero-fill.
- `we`  in  1  write enable.
- `re`  in  1  read enable.
- `addr`  in  `ADDR_W`  word address.
- `data_in`  in  `DATA_W`  write data.
- `data_out`  out  `DATA_W`  read data; holds its value between reads.
- `rd_valid`  out  1  one-cycle pulse: `data_out` was updated by a read.
- `busy`  out  1  high while a clear is in progress; accesses are not accepted.
- `err`  out  1  one-cycle pulse: the access this cycle was rejected.

## Operation
- There are two states, CLEAR and READY. `rst` forces CLEAR with the clear counter `cnt`=0.
- **CLEAR state**
  - Each edge writes 0 to `mem[cnt]` and increments `cnt`.
  - The edge that writes `DEPTH-1` moves the FSM to READY.
  - `busy` = (state == CLEAR).
- **`clr` input**
  - In READY, `clr`=1 moves the FSM to CLEAR with `cnt`=0 on the next edge.
  - In CLEAR, `clr`=1 restarts `cnt` at 0.
  - `clr` has priority over `we` and `re` in the same cycle.
- **READY state, address in range (`addr` < `DEPTH`)**
  - `we`=1: `mem[addr]` ← `data_in`.
  - `re`=1: `data_out` ← `mem[addr]`, and `rd_valid`=1 on the next cycle.
  - `we` and `re` together: both are performed. `data_out` takes `data_in` if `WRITE_FIRST`=1, otherwise the old `mem[addr]`.
- **Rejected accesses**
  - A rejected access is any `we` or `re` that is out of range (`addr` ≥ `DEPTH`), or that arrives while in CLEAR, or in the same cycle as `clr`.
  - Memory is not written and `data_out` is unchanged.
  - `err`=1 and `rd_valid`=0 on the next cycle.
- **Idle:** with `we`=`re`=0, no outputs change except that the `rd_valid` and `err` pulses drop to 0.
- **Storage:** memory contents are not reset by `rst`. Only the clear engine zeroes them.

## Timing
- Reset values: `data_out`=0, `rd_valid`=0, `err`=0, `busy`=1, state=CLEAR, `cnt`=0.
- After `rst` is released, `busy` is high for exactly `DEPTH` rising edges. The first accepted access is in the cycle after `busy` falls, i.e. on the edge `DEPTH`+1.
- Read latency is one edge: `re` sampled at edge k means `data_out` and `rd_valid` are valid after edge k.
- Back-to-back reads are accepted every cycle, so `rd_valid` stays high continuously.
- `rst` asserted mid-clear or mid-access returns to CLEAR immediately. A partial clear is then restarted from address 0.
- `err` and `rd_valid` are never both high in the same cycle.
- `cnt` is `ADDR_W`+1 bits wide so that a `DEPTH`=2^`ADDR_W` configuration terminates with no wrap ambiguity.

## Structure
- Package `ram_pkg`:
  - state enum `{CLEAR, READY}`;
  - default parameter constants;
  - a `WRITE_FIRST` mode constant.
- Sub-module `ram_array`:
  - storage only, with one synchronous write port and one synchronous read port;
  - no reset;
  - parameterised by `DATA_W` and `DEPTH`.
- `ram_clr` contains the FSM, the clear counter, the write mux (clear zero versus `data_in`), range checking, the bypass for `WRITE_FIRST`, and the strobes.

## Test plan
- **Reset and clear:** pulse `rst`, then count edges with `busy`=1. Expect exactly 256, and a read of addresses 0, 128 and 255 to return 0x00 with `rd_valid`=1.
- **Write then read:** write 0xA5 to 0x10, then read 0x10 on the next cycle. Expect `data_out`=0xA5 one edge after `re` and `rd_valid` pulsed for one cycle.
- **Read-during-write:** 0x10 holds 0xA5; drive `we`=`re`=1 with `data_in`=0x3C.
  - `WRITE_FIRST`=1: expect `data_out`=0x3C.
  - `WRITE_FIRST`=0: expect 0xA5.
  - Either way, a subsequent read returns 0x3C.
- **Out of range and busy (`DEPTH`=200):**
  - Write to 0xC8: expect `err` pulse, no write, and `data_out` unchanged.
  - Read during a clear: expect `err`=1 and `rd_valid`=0.
- **`clr` mid-operation:** write 0xFF to 0x05, then assert `clr` together with `we` to 0x06. Expect `err` pulse and `busy` high for 256 edges, then both 0x05 and 0x06 read back as 0x00.
- **`rst` mid-clear:** assert `rst` at `cnt`=100. Expect all outputs to return to reset values asynchronously, then a full 256-edge clear.
